// File: rtl/urna_pkg.sv
// urna_pkg: shared state encoding, candidate codes and saturating counter helper
package urna_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, D1 = 3'd1, D2 = 3'd2, D3 = 3'd3, FULL = 3'd4} state_e;
  localparam logic [15:0] CODE_C1 = 16'h3494;
  localparam logic [15:0] CODE_C2 = 16'h3485;
  localparam logic [15:0] CODE_C3 = 16'h3472;
  localparam logic [15:0] CODE_C4 = 16'h3504;
  localparam logic [7:0] COUNT_MAX = 8'd255;
  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return x == COUNT_MAX ? x : x + 8'd1;
  endfunction
endpackage

// File: rtl/urna_voting_machine_if.sv
// urna_voting_machine_if: keypad strobes in, tallies and vote-in-progress flag out
interface urna_voting_machine_if;
  logic [3:0] digit;
  logic valid;
  logic finish;
  logic [7:0] c1, c2, c3, c4, nulo;
  logic status;
  modport master(output digit, valid, finish, input c1, c2, c3, c4, nulo, status);
  modport slave(input digit, valid, finish, output c1, c2, c3, c4, nulo, status);
endinterface

// File: rtl/urna_edge_detect.sv
// urna_edge_detect: registers the previous sample and flags a rise (or fall when FALL=1)
module urna_edge_detect #(
  parameter bit FALL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);
  logic q;
  always_ff @(posedge clk)
    if (!rst_n) q <= 1'b0;
    else q <= d;
  assign pulse = FALL ? (q & ~d) : (~q & d);
endmodule

// File: rtl/urna_voting_machine.sv
// urna_voting_machine: collects a 4-digit BCD code and tallies it on a Finish rise
module urna_voting_machine
  import urna_pkg::*;
(
  input logic clk,
  input logic rst_n,
  urna_voting_machine_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'(IDLE);
  localparam logic [2:0] S_FULL = 3'(FULL);
  logic v_fall, f_rise;
  logic [2:0] state;
  logic [15:0] code_q;
  logic [7:0] c1, c2, c3, c4, nulo;
  logic full, h1, h2, h3, h4, hn;
  urna_edge_detect #(.FALL(1'b1)) u_valid (.clk(clk), .rst_n(rst_n), .d(bus.valid), .pulse(v_fall));
  urna_edge_detect #(.FALL(1'b0)) u_finish (.clk(clk), .rst_n(rst_n), .d(bus.finish), .pulse(f_rise));
  always_comb begin
    full = state == S_FULL;
    h1 = full && code_q == CODE_C1;
    h2 = full && code_q == CODE_C2;
    h3 = full && code_q == CODE_C3;
    h4 = full && code_q == CODE_C4;
    hn = state != S_IDLE && !(h1 || h2 || h3 || h4);
  end
  // digits shift in from the right, so after four the first one sits in the MS nibble
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      code_q <= '0;
      c1 <= '0;
      c2 <= '0;
      c3 <= '0;
      c4 <= '0;
      nulo <= '0;
    end else if (f_rise) begin
      c1 <= h1 ? sat_inc(c1) : c1;
      c2 <= h2 ? sat_inc(c2) : c2;
      c3 <= h3 ? sat_inc(c3) : c3;
      c4 <= h4 ? sat_inc(c4) : c4;
      nulo <= hn ? sat_inc(nulo) : nulo;
      state <= S_IDLE;
      code_q <= '0;
    end else if (v_fall && !full) begin
      code_q <= {code_q[11:0], bus.digit};
      state <= state + 3'd1;
    end
  assign bus.c1 = c1;
  assign bus.c2 = c2;
  assign bus.c3 = c3;
  assign bus.c4 = c4;
  assign bus.nulo = nulo;
  assign bus.status = state != S_IDLE;
endmodule

// File: tb/tb_urna_voting_machine.sv
// tb_urna_voting_machine: directed stimulus with queued expectations checked by a separate monitor
module tb_urna_voting_machine;
  typedef struct {
    string name;
    logic [7:0] c1, c2, c3, c4, nulo;
    logic st;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  exp_t q[$];
  urna_voting_machine_if bus();
  urna_voting_machine dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic key(input logic [3:0] d);
    bus.digit = d;
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    tick();
  endtask
  task automatic fin();
    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
    tick();
  endtask
  task automatic vote(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) key(c[i*4 +: 4]);
    fin();
  endtask
  task automatic expect_(input string n, input logic [7:0] a, b, c, d, e, input logic s);
    exp_t x;
    x.name = n; x.c1 = a; x.c2 = b; x.c3 = c; x.c4 = d; x.nulo = e; x.st = s;
    q.push_back(x);
  endtask
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk({x.name, ".c1"}, bus.c1, x.c1);
      chk({x.name, ".c2"}, bus.c2, x.c2);
      chk({x.name, ".c3"}, bus.c3, x.c3);
      chk({x.name, ".c4"}, bus.c4, x.c4);
      chk({x.name, ".nulo"}, bus.nulo, x.nulo);
      chk({x.name, ".status"}, {7'd0, bus.status}, {7'd0, x.st});
    end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.digit = 4'd0;
    bus.valid = 1'b0;
    bus.finish = 1'b0;
    tick();
    tick();
    expect_("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    fin();
    expect_("empty_finish", 0, 0, 0, 0, 0, 0);
    key(4'd3); key(4'd4); key(4'd9); key(4'd4);
    expect_("c1_keyed", 0, 0, 0, 0, 0, 1);
    fin();
    expect_("c1_vote", 1, 0, 0, 0, 0, 0);
    vote(16'h3485);
    expect_("c2_vote", 1, 1, 0, 0, 0, 0);
    vote(16'h3472);
    expect_("c3_vote", 1, 1, 1, 0, 0, 0);
    vote(16'h3504);
    expect_("c4_vote", 1, 1, 1, 1, 0, 0);
    key(4'd3);
    expect_("first_digit", 1, 1, 1, 1, 0, 1);
    key(4'd0);
    fin();
    expect_("partial_null", 1, 1, 1, 1, 1, 0);
    vote(16'h1234);
    expect_("other_null", 1, 1, 1, 1, 2, 0);
    key(4'd3); key(4'd4); key(4'd9); key(4'd4); key(4'd7);
    fin();
    expect_("fifth_ignored", 2, 1, 1, 1, 2, 0);
    key(4'd3); key(4'd4); key(4'd9); key(4'd4);
    bus.finish = 1'b1;
    repeat (10) tick();
    expect_("finish_held", 3, 1, 1, 1, 2, 0);
    bus.finish = 1'b0;
    tick();
    vote(16'h349F);
    expect_("digit_gt9", 3, 1, 1, 1, 3, 0);
    key(4'd3); key(4'd4); key(4'd9);
    bus.digit = 4'd4;
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    bus.finish = 1'b1;
    tick();
    expect_("fall_with_rise", 3, 1, 1, 1, 4, 0);
    bus.finish = 1'b0;
    tick();
    expect_("digit_discarded", 3, 1, 1, 1, 4, 0);
    repeat (256) vote(16'h3494);
    expect_("c1_saturate", 255, 1, 1, 1, 4, 0);
    key(4'd3); key(4'd4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_("mid_vote_reset", 0, 0, 0, 0, 0, 0);
    tick();
    fin();
    expect_("finish_after_reset", 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
